// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, bus and instruction RAM signals of the fetch unit

interface instr_fetch_if #(
    parameter int n  = 16,
    parameter int AW = 7
);
    logic          FetchReq;
    logic          PCin;
    logic [n-1:0]  BusWires;
    logic [n-1:0]  MemData;
    logic [AW-1:0] MemAddr;
    logic          MemRe;
    logic [n-1:0]  IR;
    logic          IRValid;
    logic [n-1:0]  PC;
    logic          Busy;

    // master: control FSM, shared bus and RAM side; slave: the fetch unit
    modport master (
        output FetchReq, PCin, BusWires, MemData,
        input  MemAddr, MemRe, IR, IRValid, PC, Busy
    );

    modport slave (
        input  FetchReq, PCin, BusWires, MemData,
        output MemAddr, MemRe, IR, IRValid, PC, Busy
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, instruction memory read and IR capture

module instr_fetch #(
    parameter int n       = 16,
    parameter int AW      = 7,
    parameter int MEM_LAT = 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        CAPTURE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] pc;
    logic [n-1:0] ir;
    logic         ir_valid;
    logic [1:0]   cnt;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.FetchReq) state_nxt = ADDR;
            ADDR:    state_nxt = (MEM_LAT > 1) ? WAIT : CAPTURE;
            WAIT:    if (cnt == 2'd1) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // PC only moves in IDLE (bus load) or CAPTURE (increment), so the
    // address stays stable for the whole read.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pc       <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.PCin) pc <= bus.BusWires;
                end
                ADDR: begin
                    cnt <= 2'(MEM_LAT - 1);
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                end
                CAPTURE: begin
                    ir       <= bus.MemData;
                    pc       <= pc + 1'b1;
                    ir_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.MemAddr = pc[AW-1:0];
    assign bus.MemRe   = (state == ADDR);
    assign bus.IR      = ir;
    assign bus.IRValid = ir_valid;
    assign bus.PC      = pc;
    assign bus.Busy    = (state != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with an IR/PC scoreboard

module tb_instr_fetch;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
    } exp_t;

    logic        Clock;
    logic        Resetn;
    int          tests  = 0;
    int          failed = 0;
    exp_t        qa[$];
    exp_t        qc[$];
    logic [15:0] ram_a [0:127];
    logic [15:0] ram_c [0:127];
    logic [15:0] rda;
    logic [15:0] p1, p2, p3;
    logic [8:0]  vec;
    logic [5:0]  vv, vr;

    instr_fetch_if #(.n(16), .AW(7)) a_if ();
    instr_fetch_if #(.n(16), .AW(7)) c_if ();

    instr_fetch #(.n(16), .AW(7), .MEM_LAT(1)) dut_a (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (a_if.slave)
    );

    instr_fetch #(.n(16), .AW(7), .MEM_LAT(3)) dut_c (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (c_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM models: 1-cycle and 3-cycle synchronous read
    always @(posedge Clock) begin
        rda <= a_if.MemRe ? ram_a[a_if.MemAddr] : 16'hDEAD;
        p1  <= c_if.MemRe ? ram_c[c_if.MemAddr] : 16'hDEAD;
        p2  <= p1;
        p3  <= p2;
    end
    assign a_if.MemData = rda;
    assign c_if.MemData = p3;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    always @(negedge Clock) begin
        if (a_if.IRValid === 1'b1) begin
            check("a_unexpected_valid", 16'(qa.size() != 0), 16'd1);
            if (qa.size() != 0) begin
                exp_t e;
                e = qa.pop_front();
                check("a_sb_ir", a_if.IR, e.ir);
                check("a_sb_pc", a_if.PC, e.pc);
            end
        end
        if (c_if.IRValid === 1'b1) begin
            check("c_unexpected_valid", 16'(qc.size() != 0), 16'd1);
            if (qc.size() != 0) begin
                exp_t e;
                e = qc.pop_front();
                check("c_sb_ir", c_if.IR, e.ir);
                check("c_sb_pc", c_if.PC, e.pc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram_a[i] = 16'(i) ^ 16'h5A00;
            ram_c[i] = 16'(i) ^ 16'h3C00;
        end
        ram_a[0]    = 16'h1234;
        ram_a[7'h45] = 16'hBEEF;
        ram_a[7'h7F] = 16'h7F7F;
        ram_c[0]    = 16'hC0DE;
        ram_c[1]    = 16'h1111;
        Resetn = 1'b0;
        a_if.FetchReq = 0; a_if.PCin = 0; a_if.BusWires = '0;
        c_if.FetchReq = 0; c_if.PCin = 0; c_if.BusWires = '0;

        // reset then idle
        cyc();
        @(negedge Clock);
        check("rst_pc", a_if.PC, 16'h0);
        check("rst_ir", a_if.IR, 16'h0);
        check("rst_memre", a_if.MemRe, 16'h0);
        cyc();
        Resetn = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check("idle_pc", a_if.PC, 16'h0);
            check("idle_ir", a_if.IR, 16'h0);
            check("idle_valid", a_if.IRValid, 16'h0);
            check("idle_memre", a_if.MemRe, 16'h0);
            check("idle_busy", a_if.Busy, 16'h0);
            check("idle_addr", a_if.MemAddr, 16'h0);
            cyc();
        end

        // single fetch, MEM_LAT=1
        a_if.FetchReq = 1;
        qa.push_back('{ir: 16'h1234, pc: 16'h0001});
        cyc();
        a_if.FetchReq = 0;
        @(negedge Clock);
        check("s_memre", a_if.MemRe, 16'h1);
        check("s_addr", a_if.MemAddr, 16'h0);
        check("s_busy_addr", a_if.Busy, 16'h1);
        cyc();
        @(negedge Clock);
        check("s_busy_cap", a_if.Busy, 16'h1);
        check("s_memre_cap", a_if.MemRe, 16'h0);
        check("s_valid_early", a_if.IRValid, 16'h0);
        cyc();
        @(negedge Clock);
        check("s_valid", a_if.IRValid, 16'h1);
        check("s_pc", a_if.PC, 16'h0001);
        check("s_busy_done", a_if.Busy, 16'h0);
        cyc();
        @(negedge Clock);
        check("s_valid_pulse", a_if.IRValid, 16'h0);
        check("s_ir_hold", a_if.IR, 16'h1234);
        cyc();

        // back-to-back fetches from PC=0
        ram_a[0] = 16'hAAA1; ram_a[1] = 16'hBBB2; ram_a[2] = 16'hCCC3;
        a_if.FetchReq = 1; a_if.PCin = 1; a_if.BusWires = 16'h0000;
        qa.push_back('{ir: 16'hAAA1, pc: 16'h0001});
        qa.push_back('{ir: 16'hBBB2, pc: 16'h0002});
        qa.push_back('{ir: 16'hCCC3, pc: 16'h0003});
        vec = '0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            a_if.PCin = 0;
            if (k == 9) a_if.FetchReq = 0;
            @(negedge Clock);
            vec[k-1] = a_if.IRValid;
        end
        check("b2b_pulses", 16'(vec), 16'(9'b100100100));
        check("b2b_pc", a_if.PC, 16'h0003);
        cyc();
        @(negedge Clock);
        check("b2b_idle", a_if.Busy, 16'h0);
        check("b2b_novalid", a_if.IRValid, 16'h0);
        cyc();

        // branch load with fetch, then ignored load and request while busy
        a_if.FetchReq = 1; a_if.PCin = 1; a_if.BusWires = 16'h0045;
        qa.push_back('{ir: 16'hBEEF, pc: 16'h0046});
        cyc();
        a_if.BusWires = 16'h0010;
        @(negedge Clock);
        check("br_addr", a_if.MemAddr, 16'h0045);
        check("br_memre", a_if.MemRe, 16'h1);
        check("br_pc", a_if.PC, 16'h0045);
        cyc();
        a_if.FetchReq = 0; a_if.PCin = 0; a_if.BusWires = 16'h0000;
        @(negedge Clock);
        check("br_pc_busy", a_if.PC, 16'h0045);
        check("br_busy", a_if.Busy, 16'h1);
        cyc();
        @(negedge Clock);
        check("br_valid", a_if.IRValid, 16'h1);
        check("br_pc_after", a_if.PC, 16'h0046);
        cyc();
        @(negedge Clock);
        check("br_no_queued", a_if.IRValid, 16'h0);
        check("br_no_queued_busy", a_if.Busy, 16'h0);
        check("br_pc_final", a_if.PC, 16'h0046);
        cyc();

        // PC wrap and address aliasing
        a_if.FetchReq = 1; a_if.PCin = 1; a_if.BusWires = 16'hFFFF;
        qa.push_back('{ir: 16'h7F7F, pc: 16'h0000});
        cyc();
        a_if.FetchReq = 0; a_if.PCin = 0;
        @(negedge Clock);
        check("wr_addr", a_if.MemAddr, 16'h007F);
        check("wr_pc", a_if.PC, 16'hFFFF);
        cyc();
        cyc();
        @(negedge Clock);
        check("wr_valid", a_if.IRValid, 16'h1);
        check("wr_pc_wrap", a_if.PC, 16'h0000);
        cyc();
        a_if.PCin = 1; a_if.BusWires = 16'h0080;
        cyc();
        a_if.PCin = 0;
        @(negedge Clock);
        check("al_pc", a_if.PC, 16'h0080);
        check("al_addr", a_if.MemAddr, 16'h0000);
        check("al_busy", a_if.Busy, 16'h0);
        cyc();

        // MEM_LAT=3 latency
        c_if.FetchReq = 1;
        qc.push_back('{ir: 16'hC0DE, pc: 16'h0001});
        vv = '0; vr = '0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            c_if.FetchReq = 0;
            @(negedge Clock);
            vv[k-1] = c_if.IRValid;
            vr[k-1] = c_if.MemRe;
        end
        check("l3_valid_timing", 16'(vv), 16'(6'b010000));
        check("l3_memre_timing", 16'(vr), 16'(6'b000001));
        check("l3_pc", c_if.PC, 16'h0001);
        check("l3_ir", c_if.IR, 16'hC0DE);
        cyc();

        // abort during WAIT
        c_if.FetchReq = 1;
        cyc();
        c_if.FetchReq = 0;
        cyc();
        @(negedge Clock);
        check("ab_busy_wait", c_if.Busy, 16'h1);
        check("ab_memre_wait", c_if.MemRe, 16'h0);
        Resetn = 1'b0;
        #1;
        check("ab_async_pc", c_if.PC, 16'h0);
        check("ab_async_ir", c_if.IR, 16'h0);
        check("ab_async_busy", c_if.Busy, 16'h0);
        check("ab_async_valid", c_if.IRValid, 16'h0);
        cyc();
        Resetn = 1'b1;
        vv = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clock);
            vv[k-1] = c_if.IRValid;
            cyc();
        end
        check("ab_no_valid", 16'(vv), 16'h0);
        check("ab_pc", c_if.PC, 16'h0);
        check("ab_ir", c_if.IR, 16'h0);
        check("ab_idle", c_if.Busy, 16'h0);

        check("a_sb_drained", 16'(qa.size()), 16'h0);
        check("c_sb_drained", 16'(qc.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
